clock_display_scan: RTL and testbench

- Display-side reader of the digital clock's time outputs (seconds, minutes, hours, binary).
- Converts HH:MM:SS to six multiplexed, active-high 7-segment digits, with a blinking colon on the decimal points.
- Sits between the clock counter block and the board display pins.
- Snapshots the time once per scan frame so a displayed frame never mixes two different times.

---
 rtl/clock_disp_pkg.sv | 42 ++++
 rtl/bin2bcd_2dig.sv | 38 +++
 rtl/clock_display_scan.sv | 117 +++++++++++
 tb/tb_clock_display_scan.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display scanner: segment codes and digit slot indices.
package clock_disp_pkg;

  // Segment bit order is {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [2:0] DIG_SU = 3'd0;
  localparam logic [2:0] DIG_ST = 3'd1;
  localparam logic [2:0] DIG_MU = 3'd2;
  localparam logic [2:0] DIG_MT = 3'd3;
  localparam logic [2:0] DIG_HU = 3'd4;
  localparam logic [2:0] DIG_HT = 3'd5;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// Two-digit binary to BCD split using a compare/subtract ladder, plus a range check.
module bin2bcd_2dig (
  input  logic [5:0] value,
  input  logic [5:0] limit,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       invalid
);

  logic [5:0] rem;

  always_comb begin
    tens = 4'd0;
    rem  = value;
    if (value >= 6'd60) begin
      tens = 4'd6;
      rem  = value - 6'd60;
    end else if (value >= 6'd50) begin
      tens = 4'd5;
      rem  = value - 6'd50;
    end else if (value >= 6'd40) begin
      tens = 4'd4;
      rem  = value - 6'd40;
    end else if (value >= 6'd30) begin
      tens = 4'd3;
      rem  = value - 6'd30;
    end else if (value >= 6'd20) begin
      tens = 4'd2;
      rem  = value - 6'd20;
    end else if (value >= 6'd10) begin
      tens = 4'd1;
      rem  = value - 6'd10;
    end
    units   = rem[3:0];
    invalid = value > limit;
  end

endmodule

// File: rtl/clock_display_scan.sv
// Multiplexed six-digit 7-segment driver for HH:MM:SS with a per-frame time snapshot
// and a blinking colon on the decimal points of the minutes/hours units digits.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       disp_en,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRAMES - 1);

  logic [PreW-1:0] pre_q;
  logic [2:0]      idx_q;
  logic [FrmW-1:0] frame_q;
  logic            colon_q;
  logic [5:0]      snap_s_q, snap_m_q;
  logic [4:0]      snap_h_q;

  logic [3:0] s_tens, s_units, m_tens, m_units, h_tens, h_units;
  logic       s_inv, m_inv, h_inv;

  bin2bcd_2dig u_bcd_s (
    .value   (snap_s_q),
    .limit   (6'd59),
    .tens    (s_tens),
    .units   (s_units),
    .invalid (s_inv)
  );

  bin2bcd_2dig u_bcd_m (
    .value   (snap_m_q),
    .limit   (6'd59),
    .tens    (m_tens),
    .units   (m_units),
    .invalid (m_inv)
  );

  bin2bcd_2dig u_bcd_h (
    .value   ({1'b0, snap_h_q}),
    .limit   (6'd23),
    .tens    (h_tens),
    .units   (h_units),
    .invalid (h_inv)
  );

  logic       pre_wrap, end_of_frame, show;
  logic [6:0] dig_code;

  always_comb begin
    pre_wrap     = (pre_q == PreLast);
    end_of_frame = pre_wrap && (idx_q == DIG_HT);
    // Slot cycle 0 is dead time so adjacent digits never ghost into each other
    show         = (pre_q != '0) && disp_en;
  end

  always_comb begin
    dig_code = SEG_DASH;
    case (idx_q)
      DIG_SU:  dig_code = s_inv ? SEG_DASH : seg_encode(s_units);
      DIG_ST:  dig_code = s_inv ? SEG_DASH : seg_encode(s_tens);
      DIG_MU:  dig_code = m_inv ? SEG_DASH : seg_encode(m_units);
      DIG_MT:  dig_code = m_inv ? SEG_DASH : seg_encode(m_tens);
      DIG_HU:  dig_code = h_inv ? SEG_DASH : seg_encode(h_units);
      DIG_HT:  dig_code = h_inv ? SEG_DASH : seg_encode(h_tens);
      default: dig_code = SEG_DASH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q    <= '0;
      idx_q    <= DIG_SU;
      frame_q  <= '0;
      colon_q  <= 1'b1;
      snap_s_q <= '0;
      snap_m_q <= '0;
      snap_h_q <= '0;
      an       <= '0;
      seg      <= '0;
      dp       <= 1'b0;
    end else begin
      pre_q <= pre_wrap ? '0 : pre_q + PreW'(1);
      if (pre_wrap) begin
        idx_q <= (idx_q == DIG_HT) ? DIG_SU : idx_q + 3'd1;
      end
      // Snapshot at the frame boundary so one frame never mixes two times
      if (end_of_frame) begin
        snap_s_q <= seconds;
        snap_m_q <= minutes;
        snap_h_q <= hours;
        if (frame_q == FrmLast) begin
          frame_q <= '0;
          colon_q <= ~colon_q;
        end else begin
          frame_q <= frame_q + FrmW'(1);
        end
      end
      an  <= show ? (6'd1 << idx_q) : 6'd0;
      seg <= dig_code;
      dp  <= colon_q && ((idx_q == DIG_MU) || (idx_q == DIG_HU)) && show;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan: directed steps plus random input changes,
// compared against a cycle-count based arithmetic model of the scan.
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = SD * 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_en;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt      = 0;
  int ms, mm, mh;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  clock_display_scan #(
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .disp_en (disp_en),
    .seconds (seconds),
    .minutes (minutes),
    .hours   (hours),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_seg(input int idx);
    int v, lim, d;
    case (idx / 2)
      0:       begin v = ms; lim = 59; end
      1:       begin v = mm; lim = 59; end
      default: begin v = mh; lim = 23; end
    endcase
    if (v > lim) return 7'h40;
    d = (idx % 2 == 1) ? v / 10 : v % 10;
    return seg_tab[d];
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cnt);
    end
  endtask

  // One clock: predict outputs from the model, then compare on the falling edge
  task automatic step();
    int pre, idx, f;
    logic en;
    logic [5:0] an_e;
    logic [6:0] seg_e;
    logic dp_e;
    @(posedge clk);
    cnt++;
    pre   = (cnt - 1) % SD;
    idx   = ((cnt - 1) / SD) % 6;
    f     = (cnt - 1) / FRAME;
    en    = (pre != 0) && disp_en;
    an_e  = en ? 6'(1 << idx) : 6'd0;
    seg_e = digit_seg(idx);
    dp_e  = ((f / BF) % 2 == 0) && (idx == 2 || idx == 4) && en;
    if (cnt % FRAME == 0) begin
      ms = int'(seconds);
      mm = int'(minutes);
      mh = int'(hours);
    end
    @(negedge clk);
    chk("an", 8'(an), 8'(an_e));
    chk("seg", 8'(seg), 8'(seg_e));
    chk("dp", 8'(dp), 8'(dp_e));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    cnt = 0;
    ms  = 0;
    mm  = 0;
    mh  = 0;
  endtask

  initial begin
    rst     = 1'b0;
    disp_en = 1'b1;
    seconds = 6'd56;
    minutes = 6'd34;
    hours   = 5'd12;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_an", 8'(an), 8'h00);
    chk("rst_seg", 8'(seg), 8'h00);
    chk("rst_dp", 8'(dp), 8'h00);
    rst = 1'b1;

    // First slot: dead cycle then digit 0 showing the zero snapshot
    step();
    chk("first_dead_an", 8'(an), 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("first_slot_an", 8'(an), 8'h01);
      chk("first_slot_seg", 8'(seg), 8'h3F);
    end
    run(FRAME - 4);

    // Frame 1 captures 12:34:56 at its end; frame 2 shows it
    run(FRAME);
    step();
    step();
    chk("f2_su_seg", 8'(seg), 8'h7D);
    run(8);

    // Tearing: change seconds mid-frame, must wait for next boundary
    seconds = 6'd57;
    run(FRAME - 10 + FRAME);

    // Out of range minutes/hours; seconds still valid
    seconds = 6'd5;
    minutes = 6'd60;
    hours   = 5'd24;
    run(2 * FRAME);

    // Input changed so it is stable exactly at the end-of-frame edge
    run(FRAME - (cnt % FRAME) - 1);
    seconds = 6'd59;
    minutes = 6'd0;
    hours   = 5'd23;
    run(1 + FRAME);

    // Display disable while the scan keeps running
    disp_en = 1'b0;
    run(30);
    disp_en = 1'b1;
    run(FRAME);

    // Random input and enable activity
    for (int i = 0; i < 16 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        seconds = 6'($urandom_range(0, 63));
        minutes = 6'($urandom_range(0, 63));
        hours   = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 15) == 0) disp_en = ~disp_en;
      step();
    end

    // Asynchronous reset in the middle of a lit slot
    disp_en = 1'b1;
    while ((cnt % SD) != 2) step();
    #2 rst = 1'b0;
    #1;
    chk("async_an", 8'(an), 8'h00);
    chk("async_seg", 8'(seg), 8'h00);
    chk("async_dp", 8'(dp), 8'h00);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    seconds = 6'd7;
    minutes = 6'd8;
    hours   = 5'd9;
    step();
    chk("restart_dead_an", 8'(an), 8'h00);
    step();
    chk("restart_an", 8'(an), 8'h01);
    chk("restart_seg", 8'(seg), 8'h3F);
    run(3 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
